// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Turns the XOR of the data bits into the transmitted parity bit.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a true occupancy count; full/empty derive from the count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push while full is refused even if a pop happens in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write port.
    // NOTE: the array is not reset; level/pointers decide validity, so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO; frames go out back-to-back with no idle gap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1000,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int INVERT       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [DATA_BITS-1:0]        din,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    output logic                        done,
    output logic                        tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 overflow_q;

    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 bit_end;
    logic                 par_calc;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (we),
        .wdata_i (din),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign bit_end  = (cnt_q == CNT_MAX);
    assign par_calc = parity_bit(^fifo_rdata, PARITY);
    assign empty    = fifo_empty && (state_q == ST_IDLE);
    assign overflow = overflow_q;
    assign done     = done_q;
    // Polarity inversion lives only at the pin; everything inside is true-polarity.
    assign tx       = (INVERT != 0) ? ~tx_q : tx_q;

    // Frame sequencer: next state, bit timer, shifter and the line level for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    par_d   = par_calc;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shreg_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_PARITY: begin
                tx_d = par_q;
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = fifo_rdata;
                            par_d   = par_calc;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any frame and returns the line to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            overflow_q <= we && full;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four frame configurations, table-driven single
// frames plus hand-written back-to-back, overflow and mid-frame reset sequences.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    typedef struct {
        int         d;
        logic [8:0] data;
        string      bits;   // expected pin level per serial bit, in transmit order
    } vec_t;

    // Per-instance frame configuration: 0 = 8E1, 1 = 7O2, 2 = 8E1 depth 4, 3 = 8N1 inverted.
    int cfg_db  [4] = '{8, 7, 8, 8};
    int cfg_par [4] = '{2, 1, 2, 0};
    int cfg_sb  [4] = '{1, 2, 1, 1};
    int cfg_inv [4] = '{0, 0, 0, 1};

    logic       clk;
    logic       rst;
    logic       we_v   [4];
    logic [8:0] din_v  [4];
    logic       tx_w   [4];
    logic       full_w [4];
    logic       empty_w[4];
    logic       ovf_w  [4];
    logic       done_w [4];
    logic [4:0] lvl_a, lvl_b, lvl_d;
    logic [2:0] lvl_c;

    int n_checks = 0;
    int n_errors = 0;

    bit         exp_tx_q   [$];
    bit         exp_done_q [$];
    bit         exp_ovf_q  [$];
    int         exp_lvl_q  [$];
    int         exp_full_q [$];
    int         exp_empty_q[$];
    logic [8:0] byte_q     [$];

    vec_t vecs[5];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                   .FIFO_DEPTH(16), .INVERT(0)) u_a (
        .clk(clk), .rst(rst), .we(we_v[0]), .din(din_v[0][7:0]), .full(full_w[0]),
        .empty(empty_w[0]), .level(lvl_a), .overflow(ovf_w[0]), .done(done_w[0]), .tx(tx_w[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                   .FIFO_DEPTH(16), .INVERT(0)) u_b (
        .clk(clk), .rst(rst), .we(we_v[1]), .din(din_v[1][6:0]), .full(full_w[1]),
        .empty(empty_w[1]), .level(lvl_b), .overflow(ovf_w[1]), .done(done_w[1]), .tx(tx_w[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                   .FIFO_DEPTH(4), .INVERT(0)) u_c (
        .clk(clk), .rst(rst), .we(we_v[2]), .din(din_v[2][7:0]), .full(full_w[2]),
        .empty(empty_w[2]), .level(lvl_c), .overflow(ovf_w[2]), .done(done_w[2]), .tx(tx_w[2]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .FIFO_DEPTH(16), .INVERT(1)) u_d (
        .clk(clk), .rst(rst), .we(we_v[3]), .din(din_v[3][7:0]), .full(full_w[3]),
        .empty(empty_w[3]), .level(lvl_d), .overflow(ovf_w[3]), .done(done_w[3]), .tx(tx_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lvl_of(input int d);
        case (d)
            0:       return int'(lvl_a);
            1:       return int'(lvl_b);
            2:       return int'(lvl_c);
            default: return int'(lvl_d);
        endcase
    endfunction

    function automatic bit idle_pin(input int d);
        return (cfg_inv[d] != 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_exp();
        exp_tx_q.delete();
        exp_done_q.delete();
        exp_ovf_q.delete();
        exp_lvl_q.delete();
        exp_full_q.delete();
        exp_empty_q.delete();
        byte_q.delete();
    endtask

    task automatic push_cycle(input bit pin, input bit dn);
        exp_tx_q.push_back(pin);
        exp_done_q.push_back(dn);
        exp_ovf_q.push_back(1'b0);
        exp_lvl_q.push_back(-1);
        exp_full_q.push_back(-1);
        exp_empty_q.push_back(-1);
    endtask

    task automatic pad_idle(input int d, input int n);
        for (int i = 0; i < n; i++) push_cycle(idle_pin(d), 1'b0);
    endtask

    task automatic add_bit(input bit pin, input bit last);
        for (int k = 0; k < CPB; k++) push_cycle(pin, last && (k == CPB - 1));
    endtask

    // Reference frame model: start, data LSB first, optional parity, stop bits.
    task automatic model_frame(input int d, input logic [8:0] data);
        bit b[$];
        bit p;
        p = 1'b0;
        b.push_back(1'b0);
        for (int i = 0; i < cfg_db[d]; i++) begin
            b.push_back(data[i]);
            p = p ^ data[i];
        end
        if (cfg_par[d] != 0) b.push_back((cfg_par[d] == 1) ? ~p : p);
        for (int i = 0; i < cfg_sb[d]; i++) b.push_back(1'b1);
        for (int i = 0; i < b.size(); i++)
            add_bit(b[i] ^ (cfg_inv[d] != 0), i == b.size() - 1);
    endtask

    // Sample at each falling edge, then drive the next push; byte_q[c] is pushed at cycle c.
    task automatic run_stream(input int d, input string name);
        int nb;
        nb = byte_q.size();
        for (int c = 0; c < exp_tx_q.size(); c++) begin
            @(negedge clk);
            check($sformatf("%s c%0d tx", name, c), tx_w[d], exp_tx_q[c]);
            check($sformatf("%s c%0d done", name, c), done_w[d], exp_done_q[c]);
            check($sformatf("%s c%0d overflow", name, c), ovf_w[d], exp_ovf_q[c]);
            if (exp_lvl_q[c] >= 0)
                check($sformatf("%s c%0d level", name, c), lvl_of(d), exp_lvl_q[c]);
            if (exp_full_q[c] >= 0)
                check($sformatf("%s c%0d full", name, c), full_w[d], exp_full_q[c]);
            if (exp_empty_q[c] >= 0)
                check($sformatf("%s c%0d empty", name, c), empty_w[d], exp_empty_q[c]);
            if (c < nb) begin
                we_v[d]  = 1'b1;
                din_v[d] = byte_q[c];
            end else begin
                we_v[d] = 1'b0;
            end
        end
        we_v[d] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{d: 0, data: 9'h0A5, bits: "01010010101"};   // 8E1
        vecs[1] = '{d: 1, data: 9'h000, bits: "00000000111"};   // 7O2, odd parity = 1
        vecs[2] = '{d: 3, data: 9'h0FF, bits: "1000000000"};    // 8N1 inverted pin
        vecs[3] = '{d: 2, data: 9'h007, bits: "01110000011"};   // 8E1, three ones -> parity 1
        vecs[4] = '{d: 1, data: 9'h05A, bits: "00101101111"};   // 7O2, four ones -> parity 1

        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            we_v[d]  = 1'b0;
            din_v[d] = '0;
        end

        // Reset state of every instance.
        #12;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset d%0d tx", d), tx_w[d], idle_pin(d));
            check($sformatf("reset d%0d full", d), full_w[d], 1'b0);
            check($sformatf("reset d%0d empty", d), empty_w[d], 1'b1);
            check($sformatf("reset d%0d level", d), lvl_of(d), 0);
            check($sformatf("reset d%0d overflow", d), ovf_w[d], 1'b0);
            check($sformatf("reset d%0d done", d), done_w[d], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frames from the hand-computed table.
        for (int v = 0; v < 5; v++) begin
            clear_exp();
            pad_idle(vecs[v].d, 3);
            for (int i = 0; i < vecs[v].bits.len(); i++)
                for (int k = 0; k < CPB; k++)
                    push_cycle(vecs[v].bits[i] == "1",
                               (i == vecs[v].bits.len() - 1) && (k == CPB - 1));
            pad_idle(vecs[v].d, 4);
            exp_empty_q[0] = 1;
            exp_empty_q[1] = 0;
            exp_empty_q[2] = 0;
            exp_lvl_q[1]   = 1;
            exp_lvl_q[2]   = 0;
            exp_empty_q[exp_empty_q.size() - 1] = 1;
            byte_q.push_back(vecs[v].data);
            run_stream(vecs[v].d, $sformatf("vec%0d", v));
        end

        // Back-to-back: three pushes on consecutive cycles, frames with no idle gap.
        clear_exp();
        pad_idle(0, 3);
        model_frame(0, 9'h055);
        model_frame(0, 9'h00F);
        model_frame(0, 9'h0F0);
        pad_idle(0, 4);
        exp_lvl_q[1] = 1;
        exp_lvl_q[2] = 1;
        exp_lvl_q[3] = 2;
        exp_empty_q[0] = 1;
        exp_empty_q[1] = 0;
        exp_empty_q[exp_empty_q.size() - 1] = 1;
        byte_q = '{9'h055, 9'h00F, 9'h0F0};
        run_stream(0, "b2b");

        // Overflow on the depth-4 instance: 5 accepted, the 6th dropped and never sent.
        clear_exp();
        pad_idle(2, 3);
        model_frame(2, 9'h011);
        model_frame(2, 9'h022);
        model_frame(2, 9'h033);
        model_frame(2, 9'h044);
        model_frame(2, 9'h055);
        pad_idle(2, 8);
        exp_lvl_q[1] = 1;
        exp_lvl_q[2] = 1;
        exp_lvl_q[3] = 2;
        exp_lvl_q[4] = 3;
        exp_lvl_q[5] = 4;
        exp_lvl_q[6] = 4;
        exp_full_q[4] = 0;
        exp_full_q[5] = 1;
        exp_full_q[6] = 1;
        exp_ovf_q[6]  = 1'b1;
        exp_empty_q[0] = 1;
        exp_empty_q[1] = 0;
        exp_empty_q[exp_empty_q.size() - 1] = 1;
        byte_q = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};
        run_stream(2, "ovf");

        // Reset in the middle of the data bits of 0x3C with 0x99 still queued.
        @(negedge clk);
        we_v[0] = 1'b1;
        din_v[0] = 9'h03C;
        @(negedge clk);
        din_v[0] = 9'h099;
        @(negedge clk);
        we_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mid pre tx", tx_w[0], 1'b0);
        check("rst_mid pre level", lvl_of(0), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid tx", tx_w[0], 1'b1);
        check("rst_mid level", lvl_of(0), 0);
        check("rst_mid empty", empty_w[0], 1'b1);
        check("rst_mid done", done_w[0], 1'b0);
        check("rst_mid full", full_w[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;

        clear_exp();
        pad_idle(0, 3);
        model_frame(0, 9'h081);
        pad_idle(0, 4);
        exp_lvl_q[1] = 1;
        exp_lvl_q[2] = 0;
        exp_empty_q[0] = 1;
        exp_empty_q[exp_empty_q.size() - 1] = 1;
        byte_q.push_back(9'h081);
        run_stream(0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
